// File: rtl/soc_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
//   - word offsets of the register window (TXDATA, STATUS, DIVISOR)
//   - bit positions of the STATUS fields
//   - transmitter FSM state encoding
//   - helper that maps the programmed divisor to the divisor actually used
package soc_mmio_pkg;

    // Word offsets inside the window, i.e. address[3:2]
    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_DIVISOR = 2'd2;

    // STATUS bit positions; the FIFO count occupies bits [12:4]
    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_W   = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // A programmed divisor of zero behaves like one clock per bit
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst          : clock, synchronous active-high reset
//   push, wdata       : write request and data (ignored while full)
//   pop, rdata        : read request (ignored while empty); rdata shows the head
//   full, empty, count: occupancy, count ranges 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == CW'(0));
    assign count     = count_q;
    assign rdata     = mem_q[rd_ptr_q];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Next pointers and occupancy; simultaneous push and pop keep count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because empty masks them
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter (8N1) with a TX FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   address       : CPU byte address; window = BASE_ADDR + {0x0 TXDATA, 0x4 STATUS, 0x8 DIVISOR}
//   write_data    : CPU store data
//   w_en_mem      : store strobe
//   r_en_mem      : load strobe
//   mmio_hit      : combinational window decode (SoC uses it to steer loads and block RAM writes)
//   mmio_rdata    : load data, valid the cycle after r_en_mem, zero otherwise
//   tx            : serial line, idle high
module mmio_uart_tx
    import soc_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0080_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          RESET_DIV  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        w_en_mem,
    input  logic        r_en_mem,
    output logic        mmio_hit,
    output logic [31:0] mmio_rdata,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]  word_s;
    logic        hit_s;
    logic        wr_txdata_s, wr_status_s, wr_div_s;
    logic        push_s, pop_s;
    logic [7:0]  fifo_rdata_s;
    logic        fifo_full_s, fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic [31:0] status_s;
    logic        tick_end_s;
    logic        unused_s;

    logic        ovf_q, ovf_d;
    logic [15:0] div_q, div_d;
    logic [31:0] rdata_q, rdata_d;
    uart_state_e state_q, state_d;
    logic [15:0] tick_q, tick_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] divl_q, divl_d;
    logic        tx_q, tx_d;

    // address[1:0] is ignored by design; only low data bits are meaningful
    assign unused_s    = ^{address[1:0], write_data[31:16]};

    assign word_s      = address[3:2];
    assign hit_s       = (address[31:4] == BASE_ADDR[31:4]) && (word_s != 2'd3);
    assign mmio_hit    = hit_s;
    assign wr_txdata_s = w_en_mem && hit_s && (word_s == OFF_TXDATA);
    assign wr_status_s = w_en_mem && hit_s && (word_s == OFF_STATUS);
    assign wr_div_s    = w_en_mem && hit_s && (word_s == OFF_DIVISOR);
    // Fullness is judged at cycle start, so a same-cycle pop never rescues a push
    assign push_s      = wr_txdata_s && !fifo_full_s;
    assign tick_end_s  = (tick_q == (divl_q - 16'd1));
    assign mmio_rdata  = rdata_q;
    assign tx          = tx_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (write_data[7:0]),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // STATUS word assembly
    always_comb begin
        status_s = 32'd0;
        status_s[STAT_FULL]  = fifo_full_s;
        status_s[STAT_EMPTY] = fifo_empty_s;
        status_s[STAT_BUSY]  = (state_q != ST_IDLE);
        status_s[STAT_OVF]   = ovf_q;
        status_s[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count_s);
    end

    // Register-file next state: overflow flag, divisor, load data
    always_comb begin
        ovf_d   = ovf_q;
        div_d   = div_q;
        rdata_d = 32'd0;
        if (wr_status_s) begin
            ovf_d = 1'b0;
        end else if (wr_txdata_s && fifo_full_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
        if (wr_div_s) begin
            div_d = write_data[15:0];
        end else begin
            div_d = div_q;
        end
        if (r_en_mem && hit_s) begin
            case (word_s)
                OFF_STATUS:  rdata_d = status_s;
                OFF_DIVISOR: rdata_d = {16'd0, div_q};
                default:     rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = 32'd0;
        end
    end

    // Transmitter FSM next state; the divisor is latched at pop so a
    // DIVISOR write mid-frame only affects the following frame
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        divl_d  = divl_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_rdata_s;
                    divl_d  = eff_div(div_q);
                    tick_d  = 16'd0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_end_s) begin
                    tick_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    tick_d  = tick_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (tick_end_s) begin
                    tick_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (tick_end_s) begin
                    tick_d = 16'd0;
                    // Chain straight into the next start bit when data is waiting
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_rdata_s;
                        divl_d  = eff_div(div_q);
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Line level follows the state being entered so tx stays registered
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q   <= 1'b0;
            div_q   <= 16'(RESET_DIV);
            rdata_q <= 32'd0;
            state_q <= ST_IDLE;
            tick_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            divl_q  <= eff_div(16'(RESET_DIV));
            tx_q    <= 1'b1;
        end else begin
            ovf_q   <= ovf_d;
            div_q   <= div_d;
            rdata_q <= rdata_d;
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            divl_q  <= divl_d;
            tx_q    <= tx_d;
        end
    end

endmodule
